run_monitor: RTL
================

# run_monitor

Parametrised self-checking run monitor for the pipelined MIPS datapath used in the SAD motion-estimation program. It sits beside `toplevel` in simulation and in on-board debug builds, taps `PC_PCRes`, `v0` and `v1`, and detects program completion by PC stagnation (jump-to-self). On completion it captures results, compares them against expected values and reports pass, fail or timeout with a cycle count. It replaces open-ended free-running benches, where the run stopped only on a manual halt and results were inspected by eye.

## Interface
- `PC_WIDTH`, 32, width of the monitored PC.
- `DATA_WIDTH`, 32, width of `v0`/`v1` and expected values.
- `CNT_WIDTH`, 32, width of `cycle_count`.
- `HALT_CYCLES`, 4, consecutive unchanged-PC cycles that constitute a halt; must be ≥1.
- `TIMEOUT_CYCLES`, 1000000, RUN cycles allowed before timeout; must be ≥2 and < 2^CNT_WIDTH.

Ports:
- `Clk`  in  1  single clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `PC_PCRes`  in  PC_WIDTH  current PC from the datapath.
- `v0`, `v1`  in  DATA_WIDTH  result registers from the datapath.
- `exp_v0`, `exp_v1`  in  DATA_WIDTH  expected results; must be held static during a run.
- `check_en`  in  1  1 = compare the captured values; 0 = any halt passes.
- `done`  out  1  run finished (halt or timeout); sticky.
- `pass`, `fail`, `timeout`  out  1  verdict flags; sticky.
- `cycle_count`  out  CNT_WIDTH  RUN cycles elapsed; frozen at finish.
- `halt_pc`  out  PC_WIDTH  PC at detection.
- `cap_v0`, `cap_v1`  out  DATA_WIDTH  `v0`/`v1` at detection.
- `update_count`  out  16  cycles in which `v0` or `v1` changed.

## Operation
- States: ARM, RUN, CHECK, DONE, TOUT.
- While `Reset`=1 at an edge, the monitor enters ARM and clears every output and internal register to 0.
- ARM moves to RUN at the first edge with `Reset`=0.
- RUN, every cycle:
  - `cycle_count` increments.
  - `prev_pc`, `prev_v0` and `prev_v1` register the current inputs.
  - `prev_valid` is set to 1.
- Stability counter `stab`:
  - If `prev_valid` and `PC_PCRes`==`prev_pc`, then `stab`<=`stab`+1, saturating at HALT_CYCLES.
  - Otherwise `stab`<=0.
  - The first RUN cycle never counts, because `prev_valid`=0.
- Halt detect: in RUN, with `prev_valid`=1, `PC_PCRes`==`prev_pc` and `stab`==HALT_CYCLES-1. On that edge:
  - `halt_pc`, `cap_v0` and `cap_v1` load the current inputs.
  - The FSM moves to CHECK.
- CHECK lasts one cycle:
  - `pass` <= !`check_en` | (`cap_v0`==`exp_v0` & `cap_v1`==`exp_v1`).
  - `fail` <= the complement of `pass`.
  - `done` <= 1.
  - The FSM moves to DONE.
- Timeout: in RUN, when `cycle_count`==TIMEOUT_CYCLES-1 and no halt is detected on the same edge:
  - `cap_v0`, `cap_v1` and `halt_pc` load the current inputs.
  - `timeout`, `fail` and `done` <= 1; `pass` stays 0.
  - The FSM moves to TOUT.
- Simultaneous halt and timeout on one edge: halt wins, and `timeout` stays 0.
- `update_count`:
  - Increments in RUN when `prev_valid` and (`v0`!=`prev_v0` or `v1`!=`prev_v1`).
  - Counts once per cycle even if both registers change.
  - Saturates at 16'hFFFF.
- DONE and TOUT are absorbing: all outputs hold until `Reset`.
- `Reset` mid-run or after finish aborts the run and clears everything on that edge; the next run restarts from ARM.
- Equality compares are full-width and unsigned.

## Timing
- Reset values: every output is 0.
- `cycle_count` starts counting on the first RUN edge. It equals the number of RUN edges, including the detection edge, and freezes when the FSM leaves RUN.
- PC constant from RUN cycle k (first cycle at the final value) onward:
  - Detection occurs at edge k+HALT_CYCLES.
  - `cap_*` and `halt_pc` are valid after that edge.
  - `done`, `pass` and `fail` are valid one edge later (CHECK→DONE).
- Timeout: `done`, `timeout` and `fail` are valid one edge after `cycle_count` reads TIMEOUT_CYCLES-1, i.e. on the same edge it reaches TIMEOUT_CYCLES.
- No combinational path from any input to any output.

## Test plan
- **Normal halt with matching results.** HALT_CYCLES=4. PC steps 0,4,8,…,0x40, then holds 0x40 from RUN cycle 17; `v0`=0x10, `v1`=0x20; `exp` matches; `check_en`=1. Required: detection at edge 21, `halt_pc`=0x40, `pass`=1, `fail`=0, `done`=1 one edge later, `cycle_count`=21.
- **Result mismatch.** Same stimulus, `exp_v1`=0x24. Required: `fail`=1, `pass`=0, `cap_v1`=0x20. The same stimulus with `check_en`=0 gives `pass`=1.
- **Timeout.** TIMEOUT_CYCLES=50, PC increments every cycle. Required: `timeout`=`fail`=`done`=1, `pass`=0, `cycle_count`=50, and all outputs stable for 100 further cycles.
- **Halt/timeout tie.** TIMEOUT_CYCLES=21 with the scenario-1 PC stream. Required: `pass`=1, `timeout`=0.
- **Short stall is not a halt.** PC holds one value for 3 cycles, then moves, with HALT_CYCLES=4. Required: no detection, and `stab` restarts. Separately, `v0` and `v1` change together on 5 cycles and `v0` alone on 2. Required: `update_count`=7.
- **Reset mid-run and after done.** Assert `Reset` for 1 cycle at RUN cycle 10. Required: all outputs 0 on that edge, then a clean rerun to scenario-1 results with `cycle_count`=21. Reset after `done` clears all outputs.

Source files
------------

// File: rtl/run_monitor.sv
// run_monitor: detects program halt by PC stagnation, captures and checks results, reports verdict
module run_monitor #(
    parameter int PC_WIDTH       = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 32,
    parameter int HALT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [PC_WIDTH-1:0]   PC_PCRes,
    input  logic [DATA_WIDTH-1:0] v0,
    input  logic [DATA_WIDTH-1:0] v1,
    input  logic [DATA_WIDTH-1:0] exp_v0,
    input  logic [DATA_WIDTH-1:0] exp_v1,
    input  logic                  check_en,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [PC_WIDTH-1:0]   halt_pc,
    output logic [DATA_WIDTH-1:0] cap_v0,
    output logic [DATA_WIDTH-1:0] cap_v1,
    output logic [15:0]           update_count
);
    localparam int SW = $clog2(HALT_CYCLES + 1);

    typedef enum logic [2:0] {ARM, RUN, CHECK, DONE, TOUT} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]   prev_pc_q, prev_pc_d, halt_pc_q, halt_pc_d;
    logic [DATA_WIDTH-1:0] prev_v0_q, prev_v0_d, prev_v1_q, prev_v1_d;
    logic [DATA_WIDTH-1:0] cap_v0_q, cap_v0_d, cap_v1_q, cap_v1_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic [SW-1:0]         stab_q, stab_d;
    logic [15:0]           upd_q, upd_d;
    logic                  pc_same, halt_det, tout_det;

    // Halt wins over timeout when both fire on the same edge
    always_comb begin
        pc_same  = prev_valid_q && (PC_PCRes == prev_pc_q);
        halt_det = (state_q == RUN) && pc_same && (stab_q == SW'(HALT_CYCLES - 1));
        tout_det = (state_q == RUN) && !halt_det && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ARM;
        else       state_q <= state_d;
    end

    // Next-state logic; DONE and TOUT hold until reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARM:     state_d = RUN;
            RUN:     state_d = halt_det ? CHECK : tout_det ? TOUT : RUN;
            CHECK:   state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    // Datapath next values: counters, history, capture and verdict
    always_comb begin
        cnt_d        = cnt_q;
        prev_pc_d    = prev_pc_q;
        prev_v0_d    = prev_v0_q;
        prev_v1_d    = prev_v1_q;
        prev_valid_d = prev_valid_q;
        stab_d       = stab_q;
        upd_d        = upd_q;
        halt_pc_d    = halt_pc_q;
        cap_v0_d     = cap_v0_q;
        cap_v1_d     = cap_v1_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        if (state_q == RUN) begin
            cnt_d        = cnt_q + CNT_WIDTH'(1);
            prev_pc_d    = PC_PCRes;
            prev_v0_d    = v0;
            prev_v1_d    = v1;
            prev_valid_d = 1'b1;
            stab_d       = !pc_same ? '0 : (stab_q == SW'(HALT_CYCLES)) ? stab_q : stab_q + SW'(1);
            if (prev_valid_q && (v0 != prev_v0_q || v1 != prev_v1_q) && upd_q != 16'hFFFF)
                upd_d = upd_q + 16'd1;
            if (halt_det || tout_det) begin
                halt_pc_d = PC_PCRes;
                cap_v0_d  = v0;
                cap_v1_d  = v1;
            end
            if (tout_det) begin
                timeout_d = 1'b1;
                fail_d    = 1'b1;
                done_d    = 1'b1;
            end
        end
        if (state_q == CHECK) begin
            pass_d = !check_en || (cap_v0_q == exp_v0 && cap_v1_q == exp_v1);
            fail_d = !pass_d;
            done_d = 1'b1;
        end
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q        <= '0;
            prev_pc_q    <= '0;
            prev_v0_q    <= '0;
            prev_v1_q    <= '0;
            prev_valid_q <= 1'b0;
            stab_q       <= '0;
            upd_q        <= '0;
            halt_pc_q    <= '0;
            cap_v0_q     <= '0;
            cap_v1_q     <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            prev_pc_q    <= prev_pc_d;
            prev_v0_q    <= prev_v0_d;
            prev_v1_q    <= prev_v1_d;
            prev_valid_q <= prev_valid_d;
            stab_q       <= stab_d;
            upd_q        <= upd_d;
            halt_pc_q    <= halt_pc_d;
            cap_v0_q     <= cap_v0_d;
            cap_v1_q     <= cap_v1_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign cycle_count  = cnt_q;
    assign halt_pc      = halt_pc_q;
    assign cap_v0       = cap_v0_q;
    assign cap_v1       = cap_v1_q;
    assign update_count = upd_q;
endmodule
